// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs,
// FSM state numbering, ALU operation class and ALU control codes.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALUC_AND = 3'b000;
   localparam logic [2:0] ALUC_OR  = 3'b001;
   localparam logic [2:0] ALUC_ADD = 3'b010;
   localparam logic [2:0] ALUC_SUB = 3'b110;
   localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

// File: rtl/mips_alu_decoder.sv
// Purely combinational ALU control decode from the FSM's aluop class and the
// instruction funct field.
module mips_alu_decoder
   import mips_pkg::*;
(
   input  logic [1:0] i_aluop,
   input  logic [5:0] i_funct,
   output logic [2:0] o_alucontrol
);

   logic [2:0] w_alucontrol;

   // map aluop class (and funct for R-type) to the ALU operation code
   always_comb begin
      w_alucontrol = ALUC_ADD;
      case (i_aluop)
         ALUOP_ADD: w_alucontrol = ALUC_ADD;
         ALUOP_SUB: w_alucontrol = ALUC_SUB;
         ALUOP_FUNCT: begin
            case (i_funct)
               FN_ADD:  w_alucontrol = ALUC_ADD;
               FN_SUB:  w_alucontrol = ALUC_SUB;
               FN_AND:  w_alucontrol = ALUC_AND;
               FN_OR:   w_alucontrol = ALUC_OR;
               FN_SLT:  w_alucontrol = ALUC_SLT;
               default: w_alucontrol = ALUC_ADD;
            endcase
         end
         default: w_alucontrol = ALUC_ADD;
      endcase
   end

   assign o_alucontrol = w_alucontrol;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM control unit for a multicycle MIPS datapath, with a retired
// instruction counter. Reset forces every control output low combinationally.
module mips_multicycle_ctrl
   import mips_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [5:0]       i_op,
   input  logic [5:0]       i_funct,
   input  logic             i_zero,
   output logic             o_iord,
   output logic             o_memwrite,
   output logic             o_irwrite,
   output logic             o_regdst,
   output logic             o_memtoreg,
   output logic             o_regwrite,
   output logic             o_alusrca,
   output logic [1:0]       o_alusrcb,
   output logic [1:0]       o_pcsrc,
   output logic [2:0]       o_alucontrol,
   output logic             o_pcen,
   output logic             o_instr_done,
   output logic             o_illegal_op,
   output logic [CNT_W-1:0] o_instret
);

   state_t             r_state;
   state_t             w_next_state;
   logic [CNT_W-1:0]   r_instret;

   logic       w_iord, w_memwrite, w_irwrite, w_regdst, w_memtoreg, w_regwrite;
   logic       w_alusrca, w_pcwrite, w_branch, w_done, w_illegal, w_out_en;
   logic [1:0] w_alusrcb, w_pcsrc, w_aluop;
   logic [2:0] w_alu_dec;

   // state register; reset aborts any instruction in flight
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // next-state logic
   always_comb begin
      w_next_state = S_FETCH;
      case (r_state)
         S_FETCH: w_next_state = S_DECODE;
         S_DECODE: begin
            case (i_op)
               OP_LW, OP_SW: w_next_state = S_MEMADR;
               OP_RTYPE:     w_next_state = S_EXECUTE;
               OP_BEQ:       w_next_state = S_BRANCH;
               OP_ADDI:      w_next_state = S_ADDIEX;
               OP_J:         w_next_state = S_JUMP;
               default:      w_next_state = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (i_op == OP_SW) begin
               w_next_state = S_MEMWR;
            end else begin
               w_next_state = S_MEMRD;
            end
         end
         S_MEMRD:   w_next_state = S_MEMWB;
         S_EXECUTE: w_next_state = S_ALUWB;
         S_ADDIEX:  w_next_state = S_ADDIWB;
         default:   w_next_state = S_FETCH;
      endcase
   end

   // Moore output decode; unreachable encodings and reset leave everything low
   always_comb begin
      w_iord     = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      w_regdst   = 1'b0;
      w_memtoreg = 1'b0;
      w_regwrite = 1'b0;
      w_alusrca  = 1'b0;
      w_alusrcb  = 2'b00;
      w_pcsrc    = 2'b00;
      w_aluop    = ALUOP_ADD;
      w_pcwrite  = 1'b0;
      w_branch   = 1'b0;
      w_done     = 1'b0;
      w_illegal  = 1'b0;
      w_out_en   = 1'b0;
      if (!i_reset) begin
         w_out_en = 1'b1;
         case (r_state)
            S_FETCH: begin
               w_irwrite = 1'b1;
               w_alusrcb = 2'b01;
               w_pcwrite = 1'b1;
            end
            S_DECODE: begin
               w_alusrcb = 2'b11;
               case (i_op)
                  OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: w_illegal = 1'b0;
                  default:                                      w_illegal = 1'b1;
               endcase
            end
            S_MEMADR: begin
               w_alusrca = 1'b1;
               w_alusrcb = 2'b10;
            end
            S_MEMRD: w_iord = 1'b1;
            S_MEMWB: begin
               w_regwrite = 1'b1;
               w_memtoreg = 1'b1;
               w_done     = 1'b1;
            end
            S_MEMWR: begin
               w_iord     = 1'b1;
               w_memwrite = 1'b1;
               w_done     = 1'b1;
            end
            S_EXECUTE: begin
               w_alusrca = 1'b1;
               w_aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
               w_regwrite = 1'b1;
               w_regdst   = 1'b1;
               w_done     = 1'b1;
            end
            S_BRANCH: begin
               w_alusrca = 1'b1;
               w_aluop   = ALUOP_SUB;
               w_branch  = 1'b1;
               w_pcsrc   = 2'b01;
               w_done    = 1'b1;
            end
            S_ADDIEX: begin
               w_alusrca = 1'b1;
               w_alusrcb = 2'b10;
            end
            S_ADDIWB: begin
               w_regwrite = 1'b1;
               w_done     = 1'b1;
            end
            S_JUMP: begin
               w_pcsrc   = 2'b10;
               w_pcwrite = 1'b1;
               w_done    = 1'b1;
            end
            default: w_out_en = 1'b0;
         endcase
      end else begin
         w_out_en = 1'b0;
      end
   end

   mips_alu_decoder u_alu_dec (
      .i_aluop      (w_aluop),
      .i_funct      (i_funct),
      .o_alucontrol (w_alu_dec)
   );

   // retired-instruction counter, wraps naturally at all-ones
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_instret <= '0;
      end else if (w_done) begin
         r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_instret <= r_instret;
      end
   end

   assign o_iord       = w_iord;
   assign o_memwrite   = w_memwrite;
   assign o_irwrite    = w_irwrite;
   assign o_regdst     = w_regdst;
   assign o_memtoreg   = w_memtoreg;
   assign o_regwrite   = w_regwrite;
   assign o_alusrca    = w_alusrca;
   assign o_alusrcb    = w_alusrcb;
   assign o_pcsrc      = w_pcsrc;
   assign o_alucontrol = w_out_en ? w_alu_dec : 3'b000;
   assign o_pcen       = w_pcwrite | (w_branch & i_zero);
   assign o_instr_done = w_done;
   assign o_illegal_op = w_illegal;
   assign o_instret    = r_instret;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class through
// its states and checks the full control vector against hand-computed values.
module tb_mips_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  op = 6'b100011;
   logic [5:0]  funct = 6'b000000;
   logic        zero = 1'b0;

   logic        iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
   logic [1:0]  alusrcb, pcsrc;
   logic [2:0]  alucontrol;
   logic        pcen, instr_done, illegal_op;
   logic [31:0] instret;

   logic        s_iord, s_memwrite, s_irwrite, s_regdst, s_memtoreg, s_regwrite, s_alusrca;
   logic [1:0]  s_alusrcb, s_pcsrc;
   logic [2:0]  s_alucontrol;
   logic        s_pcen, s_instr_done, s_illegal_op;
   logic [3:0]  s_instret;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mips_multicycle_ctrl #(.CNT_W(32)) dut (
      .i_clk(clk), .i_reset(reset), .i_op(op), .i_funct(funct), .i_zero(zero),
      .o_iord(iord), .o_memwrite(memwrite), .o_irwrite(irwrite), .o_regdst(regdst),
      .o_memtoreg(memtoreg), .o_regwrite(regwrite), .o_alusrca(alusrca),
      .o_alusrcb(alusrcb), .o_pcsrc(pcsrc), .o_alucontrol(alucontrol), .o_pcen(pcen),
      .o_instr_done(instr_done), .o_illegal_op(illegal_op), .o_instret(instret)
   );

   mips_multicycle_ctrl #(.CNT_W(4)) dut4 (
      .i_clk(clk), .i_reset(reset), .i_op(op), .i_funct(funct), .i_zero(zero),
      .o_iord(s_iord), .o_memwrite(s_memwrite), .o_irwrite(s_irwrite), .o_regdst(s_regdst),
      .o_memtoreg(s_memtoreg), .o_regwrite(s_regwrite), .o_alusrca(s_alusrca),
      .o_alusrcb(s_alusrcb), .o_pcsrc(s_pcsrc), .o_alucontrol(s_alucontrol), .o_pcen(s_pcen),
      .o_instr_done(s_instr_done), .o_illegal_op(s_illegal_op), .o_instret(s_instret)
   );

   // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol,pcen,done,illegal}
   wire [16:0] ctl = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                      alusrcb, pcsrc, alucontrol, pcen, instr_done, illegal_op};

   function automatic logic [16:0] mk(
      input logic iord_e, input logic mw, input logic irw, input logic rd,
      input logic m2r, input logic rw, input logic asa, input logic [1:0] asb,
      input logic [1:0] pcs, input logic [2:0] aluc, input logic pce,
      input logic dn, input logic ill);
      return {iord_e, mw, irw, rd, m2r, rw, asa, asb, pcs, aluc, pce, dn, ill};
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [16:0] E_FETCH  = 17'b0_0_1_0_0_0_0_01_00_010_1_0_0;
   localparam logic [16:0] E_DECODE = 17'b0_0_0_0_0_0_0_11_00_010_0_0_0;
   localparam logic [16:0] E_MEMADR = 17'b0_0_0_0_0_0_1_10_00_010_0_0_0;
   localparam logic [16:0] E_MEMRD  = 17'b1_0_0_0_0_0_0_00_00_010_0_0_0;
   localparam logic [16:0] E_MEMWB  = 17'b0_0_0_0_1_1_0_00_00_010_0_1_0;
   localparam logic [16:0] E_MEMWR  = 17'b1_1_0_0_0_0_0_00_00_010_0_1_0;
   localparam logic [16:0] E_ALUWB  = 17'b0_0_0_1_0_1_0_00_00_010_0_1_0;
   localparam logic [16:0] E_ADDIEX = 17'b0_0_0_0_0_0_1_10_00_010_0_0_0;
   localparam logic [16:0] E_ADDIWB = 17'b0_0_0_0_0_1_0_00_00_010_0_1_0;
   localparam logic [16:0] E_JUMP   = 17'b0_0_0_0_0_0_0_00_10_010_1_1_0;
   localparam logic [16:0] E_ILLDEC = 17'b0_0_0_0_0_0_0_11_00_010_0_0_1;

   initial begin
      // reset held for two edges
      step();
      step();
      check("reset_ctl", {15'd0, ctl}, 32'd0);
      check("reset_instret", instret, 32'd0);
      reset = 1'b0;
      #1;
      check("fetch_first", {15'd0, ctl}, {15'd0, E_FETCH});

      // lw
      step(); check("lw_decode", {15'd0, ctl}, {15'd0, E_DECODE});
      step(); check("lw_memadr", {15'd0, ctl}, {15'd0, E_MEMADR});
      step(); check("lw_memrd", {15'd0, ctl}, {15'd0, E_MEMRD});
      step(); check("lw_memwb", {15'd0, ctl}, {15'd0, E_MEMWB});
      check("lw_instret_before", instret, 32'd0);
      step(); check("lw_fetch", {15'd0, ctl}, {15'd0, E_FETCH});
      check("lw_instret_after", instret, 32'd1);

      // beq taken
      op = 6'b000100; zero = 1'b1;
      step(); check("beq_decode", {15'd0, ctl}, {15'd0, E_DECODE});
      step(); check("beq_t_branch", {15'd0, ctl},
                    {15'd0, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,3'b110,1'b1,1'b1,1'b0)});
      step(); check("beq_t_fetch", {15'd0, ctl}, {15'd0, E_FETCH});
      check("beq_t_instret", instret, 32'd2);

      // beq not taken
      zero = 1'b0;
      step();
      step(); check("beq_nt_branch", {15'd0, ctl},
                    {15'd0, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,3'b110,1'b0,1'b1,1'b0)});
      step(); check("beq_nt_fetch", {15'd0, ctl}, {15'd0, E_FETCH});
      check("beq_nt_instret", instret, 32'd3);

      // R-type slt
      op = 6'b000000; funct = 6'b101010;
      step(); check("slt_decode", {15'd0, ctl}, {15'd0, E_DECODE});
      step(); check("slt_execute", {15'd0, ctl},
                    {15'd0, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b111,1'b0,1'b0,1'b0)});
      step(); check("slt_aluwb", {15'd0, ctl}, {15'd0, E_ALUWB});
      step(); check("slt_instret", instret, 32'd4);

      // R-type or
      funct = 6'b100101;
      step();
      step(); check("or_execute_aluc", {29'd0, alucontrol}, 32'd1);
      step(); check("or_aluwb", {15'd0, ctl}, {15'd0, E_ALUWB});
      step(); check("or_instret", instret, 32'd5);

      // R-type sub
      funct = 6'b100010;
      step();
      step(); check("sub_execute_aluc", {29'd0, alucontrol}, 32'd6);
      step(); step();

      // addi
      op = 6'b001000; funct = 6'b000000;
      step();
      step(); check("addi_ex", {15'd0, ctl}, {15'd0, E_ADDIEX});
      step(); check("addi_wb", {15'd0, ctl}, {15'd0, E_ADDIWB});
      step(); check("addi_instret", instret, 32'd7);

      // illegal opcode
      op = 6'b111111;
      step(); check("ill_decode", {15'd0, ctl}, {15'd0, E_ILLDEC});
      step(); check("ill_fetch", {15'd0, ctl}, {15'd0, E_FETCH});
      check("ill_instret", instret, 32'd7);

      // sw aborted by reset in MEMWR
      op = 6'b101011;
      step();
      step(); check("sw_memadr", {15'd0, ctl}, {15'd0, E_MEMADR});
      step(); check("sw_memwr", {15'd0, ctl}, {15'd0, E_MEMWR});
      reset = 1'b1;
      #1;
      check("sw_reset_ctl", {15'd0, ctl}, 32'd0);
      step();
      check("sw_reset_instret", instret, 32'd0);
      reset = 1'b0;
      #1;
      check("sw_release_fetch", {15'd0, ctl}, {15'd0, E_FETCH});

      // 17 jumps: 4-bit counter wraps to 1
      op = 6'b000010;
      for (int i = 0; i < 17; i++) begin
         step();
         step();
         if (i == 0) check("j_jump", {15'd0, ctl}, {15'd0, E_JUMP});
         step();
      end
      check("j_instret32", instret, 32'd17);
      check("j_instret4_wrap", {28'd0, s_instret}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
